reorder_buffer: RTL

Circular reorder buffer for the out-of-order LC-3b core. Dispatch allocates entries in program order, the CDB writes results into them out of order, and the commit stage drains the head in order. The commit stage sees the head as a valid/opcode/dest/value/predict bundle plus `rob_empty`. It acknowledges with a read enable and can request a full flush on branch misprediction. The buffer also serves operand lookups by tag for the issue stage.

---
 rtl/lc3b_types.sv | 31 +++
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode and register types shared by the core
//
// Purpose: shared LC-3b instruction encodings for the out-of-order core.
// Contents:
//   lc3b_opcode - 4-bit opcode enum (instruction bits [15:12])
//   lc3b_reg    - 3-bit register index (also carries nzp for branches)

package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer for the out-of-order LC-3b core
//
// Purpose: dispatch allocates entries at the tail in program order, the CDB
// completes them out of order, and commit drains the head in order. A tag
// lookup port serves operand reads for the issue stage.
//
// Optional feature: define ROB_CDB_BYPASS_EN to forward a same-cycle CDB
// broadcast onto the lookup port (src_ready/src_value).
//
// Ports:
//   clk, clr                    - clock, synchronous active-high reset
//   alloc_in/opcode/dest/predict - allocation request and its fields
//   alloc_tag, rob_full         - tag for this allocation (tail), no free entry
//   cdb_valid/tag/value         - result broadcast
//   src_tag -> src_ready/value  - operand lookup
//   valid_out, opcode_out, dest_out, value_out, predict_out - head bundle
//   rob_empty                   - no occupied entries
//   RE_in                       - commit stage consumes head
//   flush_in                    - discard all entries

module reorder_buffer
  import lc3b_types::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  alloc_in,
  input  lc3b_opcode            alloc_opcode,
  input  lc3b_reg               alloc_dest,
  input  logic                  alloc_predict,
  output logic [tag_width-1:0]  alloc_tag,
  output logic                  rob_full,
  input  logic                  cdb_valid,
  input  logic [tag_width-1:0]  cdb_tag,
  input  logic [data_width-1:0] cdb_value,
  input  logic [tag_width-1:0]  src_tag,
  output logic                  src_ready,
  output logic [data_width-1:0] src_value,
  output logic                  valid_out,
  output lc3b_opcode            opcode_out,
  output lc3b_reg               dest_out,
  output logic [data_width-1:0] value_out,
  output logic                  predict_out,
  output logic                  rob_empty,
  input  logic                  RE_in,
  input  logic                  flush_in
);

  localparam int depth = 1 << tag_width;
  localparam logic [tag_width:0] full_count = {1'b1, {tag_width{1'b0}}};

  logic                  busy      [depth];
  logic                  ready     [depth];
  lc3b_opcode            opcode_mem[depth];
  lc3b_reg               dest_mem  [depth];
  logic [data_width-1:0] value_mem [depth];
  logic                  predict_mem[depth];

  logic [tag_width-1:0]  head;
  logic [tag_width-1:0]  tail;
  logic [tag_width:0]    count;

  logic do_alloc;
  logic do_commit;
  logic cdb_hit;

  assign rob_empty = (count == '0);
  assign rob_full  = (count == full_count);
  assign alloc_tag = tail;

  // A full buffer refuses allocation even if the head retires this cycle,
  // so the decision never depends on the commit path.
  assign do_alloc  = alloc_in && !rob_full;
  assign valid_out = !rob_empty && ready[head];
  assign do_commit = RE_in && valid_out;
  assign cdb_hit   = cdb_valid && busy[cdb_tag];

  assign opcode_out  = opcode_mem[head];
  assign dest_out    = dest_mem[head];
  assign value_out   = value_mem[head];
  assign predict_out = predict_mem[head];

`ifdef ROB_CDB_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = cdb_valid && (cdb_tag == src_tag) && busy[src_tag];
  assign src_ready  = bypass_hit || (busy[src_tag] && ready[src_tag]);
  assign src_value  = bypass_hit ? cdb_value : value_mem[src_tag];
`else
  assign src_ready  = busy[src_tag] && ready[src_tag];
  assign src_value  = value_mem[src_tag];
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < depth; i++) begin
        busy[i]        <= 1'b0;
        ready[i]       <= 1'b0;
        opcode_mem[i]  <= op_br;
        dest_mem[i]    <= '0;
        value_mem[i]   <= '0;
        predict_mem[i] <= 1'b0;
      end
    end else if (flush_in) begin
      // Stored fields are left as-is; busy/ready gate every use of them.
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < depth; i++) begin
        busy[i]  <= 1'b0;
        ready[i] <= 1'b0;
      end
    end else begin
      if (do_alloc) begin
        busy[tail]        <= 1'b1;
        ready[tail]       <= 1'b0;
        opcode_mem[tail]  <= alloc_opcode;
        dest_mem[tail]    <= alloc_dest;
        predict_mem[tail] <= alloc_predict;
        tail              <= tail + 1'b1;
      end

      // The allocated slot is never busy beforehand, so a CDB write can
      // not collide with a same-cycle allocation.
      if (cdb_hit) begin
        ready[cdb_tag]     <= 1'b1;
        value_mem[cdb_tag] <= cdb_value;
      end

      // Placed last so a retiring head wins over a late CDB write to it.
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + 1'b1;
      end

      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
